// File: rtl/digit_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl_pkg
//   Shared definitions for the 4-digit multiplexed display scanner:
//   scan FSM state encoding, digit count and a small sizing helper.
// -----------------------------------------------------------------------------
package digit_scan_ctrl_pkg;

    // Scan FSM encoding (2 bit).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    localparam int NUM_DIGITS = 4;

    // Larger of two integers, used to size the shared tick counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Free-running clock divider producing a one-cycle tick every DIV cycles.
//   Counts 0..DIV-1; tick is high while the count sits at DIV-1.
// Ports
//   clk   in  1  system clock
//   rst   in  1  synchronous reset, active-high
//   clr   in  1  synchronous clear; holds the count at 0
//   tick  out 1  one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl
//   Drives the A/B select and active-low enable of a 2-to-4 digit decoder so
//   a 4-digit multiplexed display is scanned digit 0..3. Each digit slot is a
//   dark gap (BLANK_TICKS ticks) followed, if the digit is enabled, by a lit
//   period (ON_TICKS ticks). The displayed 16-bit BCD value only changes at a
//   frame boundary (idx leaving 3) or when scanning starts.
//
//   Handshake: load is a single-cycle strobe with no back-pressure; every
//   strobe is accepted. A captured value waits in a pending register until
//   the next activation point, where it becomes active and load_ack pulses.
//
// Ports
//   clk        in  1   system clock, rising edge
//   rst        in  1   synchronous reset, active-high
//   run        in  1   1 = scan, 0 = go dark and park in IDLE
//   load       in  1   one-cycle strobe capturing value
//   value      in  16  four BCD digits, digit i = value[4i+3:4i]
//   digit_en   in  4   per-digit enable mask
//   sel_a      out 1   decoder A = digit index bit 1
//   sel_b      out 1   decoder B = digit index bit 0
//   en_n       out 1   decoder enable, active-low
//   bcd        out 4   nibble of the active value for the current digit
//   frame_done out 1   pulse when the digit-3 slot ends
//   load_ack   out 1   pulse when a captured value becomes active
//
//   All outputs are registered from the current state/idx, so sel/bcd/en_n
//   all lag the internal scan position by one cycle and stay aligned.
// -----------------------------------------------------------------------------
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DIV         = 50000,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      sel_a,
    output logic                      sel_b,
    output logic                      en_n,
    output logic [3:0]                bcd,
    output logic                      frame_done,
    output logic                      load_ack
);

    localparam int TW = $clog2(max2(ON_TICKS, BLANK_TICKS) + 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] TONE       = TW'(1);

    scan_state_t            state, state_nxt;
    logic [1:0]             idx, idx_nxt;
    logic [TW-1:0]          tcnt, tcnt_nxt;
    logic                   boundary;
    logic                   start;
    logic                   activate;
    logic                   tick;
    logic                   presc_clr;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                   pend_flag;

    // Prescaler is held at zero in IDLE so every scan starts phase-aligned.
    assign presc_clr = (state == ST_IDLE);

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Next-state logic. run=0 overrides everything and parks the scan.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        boundary  = 1'b0;
        start     = 1'b0;
        if (!run) begin
            state_nxt = ST_IDLE;
            idx_nxt   = 2'd0;
            tcnt_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = 2'd0;
                    tcnt_nxt  = '0;
                    start     = 1'b1;
                end
                ST_BLANK: begin
                    if (tick) begin
                        if (tcnt == BLANK_LAST) begin
                            tcnt_nxt = '0;
                            // digit_en is only looked at here, at the end of the gap
                            if (digit_en[idx]) begin
                                state_nxt = ST_ON;
                            end else begin
                                idx_nxt  = idx + 2'd1;
                                boundary = (idx == 2'd3);
                            end
                        end else begin
                            tcnt_nxt = tcnt + TONE;
                        end
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (tcnt == ON_LAST) begin
                            tcnt_nxt  = '0;
                            state_nxt = ST_BLANK;
                            idx_nxt   = idx + 2'd1;
                            boundary  = (idx == 2'd3);
                        end else begin
                            tcnt_nxt = tcnt + TONE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = 2'd0;
                    tcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Display value may swap at a frame boundary or when a scan starts.
    assign activate = boundary || start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            tcnt       <= '0;
            active     <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            sel_a      <= 1'b0;
            sel_b      <= 1'b0;
            en_n       <= 1'b1;
            bcd        <= 4'd0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tcnt       <= tcnt_nxt;
            sel_a      <= idx[1];
            sel_b      <= idx[0];
            // Gate with run so stopping darkens the display on the next edge.
            en_n       <= !((state == ST_ON) && run);
            bcd        <= active[{idx, 2'b00} +: 4];
            frame_done <= boundary;
            load_ack   <= 1'b0;
            // A load arriving on the activation cycle beats the older pending value.
            if (activate && load) begin
                active    <= value;
                pend_flag <= 1'b0;
                load_ack  <= 1'b1;
            end else if (activate && pend_flag) begin
                active    <= pending;
                pend_flag <= 1'b0;
                load_ack  <= 1'b1;
            end else if (load) begin
                pending   <= value;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_ctrl
//   Bench for digit_scan_ctrl with DIV=4, ON_TICKS=3, BLANK_TICKS=1 and a
//   behavioural 2-to-4 decoder on the outputs. A cycle-countdown model of the
//   scan (phase lengths in clock cycles, value swap rules) predicts every
//   registered output after each edge; directed scenarios are followed by a
//   randomized run.
// -----------------------------------------------------------------------------
module tb_digit_scan_ctrl;

    localparam int DIV         = 4;
    localparam int ON_TICKS    = 3;
    localparam int BLANK_TICKS = 1;
    localparam int BLANK_CYC   = DIV * BLANK_TICKS;
    localparam int ON_CYC      = DIV * ON_TICKS;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        sel_a, sel_b, en_n;
    logic [3:0]  bcd;
    logic        frame_done, load_ack;
    logic [3:0]  dec_d;

    always #5 clk = ~clk;

    digit_scan_ctrl #(
        .DIV         (DIV),
        .ON_TICKS    (ON_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .load       (load),
        .value      (value),
        .digit_en   (digit_en),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .en_n       (en_n),
        .bcd        (bcd),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    // 2-to-4 decoder with active-low enable and outputs.
    assign dec_d = en_n ? 4'b1111 : ~(4'b0001 << {sel_a, sel_b});

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [8:0] exp_q[$];   // {en_n, sel_a, sel_b, bcd[3:0], frame_done, load_ack}
    logic [3:0] dec_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int fd_prev = 0;
    int fd_last = 0;
    int ack_cnt = 0;
    int lit_odd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_running;
    bit          m_lit;
    int          m_idx;
    int          m_left;       // cycles left in the current dark/lit phase
    logic [15:0] m_active;
    logic [15:0] m_pend_val;
    bit          m_pend;

    // True when the next edge ends the digit-3 slot (assuming run stays 1).
    function automatic bit next_is_boundary();
        return m_running && run && (m_left == 1) && (m_idx == 3) &&
               (m_lit || !digit_en[3]);
    endfunction

    task automatic model_edge();
        logic [1:0] s;
        logic [3:0] nib;
        logic       e_en;
        bit         boundary;
        bit         start;
        bit         ack;
        boundary = 1'b0;
        start    = 1'b0;
        ack      = 1'b0;
        if (rst) begin
            m_running  = 1'b0;
            m_lit      = 1'b0;
            m_idx      = 0;
            m_left     = 0;
            m_active   = '0;
            m_pend     = 1'b0;
            m_pend_val = '0;
            exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
        end else begin
            // outputs reflect the position held before this edge
            s    = 2'(m_idx);
            nib  = 4'((m_active >> (4 * m_idx)) & 16'h000F);
            e_en = !(m_running && m_lit && run);
            if (!run) begin
                m_running = 1'b0;
                m_lit     = 1'b0;
                m_idx     = 0;
            end else if (!m_running) begin
                m_running = 1'b1;
                m_lit     = 1'b0;
                m_idx     = 0;
                m_left    = BLANK_CYC;
                start     = 1'b1;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (!m_lit && digit_en[m_idx]) begin
                        m_lit  = 1'b1;
                        m_left = ON_CYC;
                    end else begin
                        boundary = (m_idx == 3);
                        m_idx    = (m_idx + 1) % 4;
                        m_lit    = 1'b0;
                        m_left   = BLANK_CYC;
                    end
                end
            end
            if ((start || boundary) && load) begin
                m_active = value;
                m_pend   = 1'b0;
                ack      = 1'b1;
            end else if ((start || boundary) && m_pend) begin
                m_active = m_pend_val;
                m_pend   = 1'b0;
                ack      = 1'b1;
            end else if (load) begin
                m_pend_val = value;
                m_pend     = 1'b1;
            end
            exp_q.push_back({e_en, s[1], s[0], nib, boundary, ack});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        logic [8:0] e;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        e = exp_q.pop_front();
        check("en_n", en_n, e[8]);
        check("sel", {sel_a, sel_b}, e[7:6]);
        check("bcd", bcd, e[5:2]);
        check("frame_done", frame_done, e[1]);
        check("load_ack", load_ack, e[0]);
        check("decoder", dec_d, e[8] ? 4'b1111 : dec_tbl[e[7:6]]);
        if (frame_done) begin
            fd_prev = fd_last;
            fd_last = cyc;
        end
        if (load_ack) ack_cnt++;
        if (!en_n && sel_b) lit_odd++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = frame_done;
        end
        check("wait_frame_done", seen, 1);
    endtask

    // Step until the display lights; returns whether it did within budget.
    task automatic wait_lit(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = !en_n;
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        bit seen;
        bit hit;
        rst      = 1'b1;
        run      = 1'b0;
        load     = 1'b0;
        value    = '0;
        digit_en = 4'b0000;
        steps(3);
        rst = 1'b0;
        steps(2);
        check("reset_decoder", dec_d, 4'b1111);

        // first activation: load while idle, then start scanning all digits
        pulse_load(16'h4321);
        run      = 1'b1;
        digit_en = 4'b1111;
        wait_fd(200);
        wait_fd(100);
        check("frame_period_1111", fd_last - fd_prev, 64);

        // only digits 0 and 2 enabled
        digit_en = 4'b0101;
        wait_fd(100);
        wait_fd(100);
        lit_odd = 0;
        wait_fd(100);
        check("frame_period_0101", fd_last - fd_prev, 40);
        check("odd_digit_lit", lit_odd, 0);

        // two loads mid-frame: only the last one shows, one ack at the boundary
        digit_en = 4'b1111;
        wait_fd(100);
        steps(10);
        pulse_load(16'h9999);
        steps(5);
        pulse_load(16'h5678);
        a0 = ack_cnt;
        wait_fd(100);
        check("ack_at_boundary", load_ack, 1);
        wait_lit(20, seen);
        check("lit_after_swap", seen, 1);
        check("bcd_digit0_after_swap", bcd, 4'h8);
        wait_fd(100);
        check("single_ack", ack_cnt - a0, 1);

        // load on the boundary cycle while an older value is pending
        pulse_load(16'h1111);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (next_is_boundary()) hit = 1'b1;
            else step();
        end
        check("found_boundary", hit, 1);
        a0 = ack_cnt;
        pulse_load(16'h2468);
        check("fd_on_load_cycle", frame_done, 1);
        check("ack_on_load_cycle", load_ack, 1);
        wait_lit(20, seen);
        check("bcd_boundary_load", bcd, 4'h8);
        wait_fd(100);
        check("boundary_single_ack", ack_cnt - a0, 1);

        // stop while digit 2 is lit, then restart from digit 0
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = m_lit && (m_idx == 2);
        end
        check("found_digit2_lit", hit, 1);
        steps(2);
        run = 1'b0;
        step();
        check("en_n_after_stop", en_n, 1);
        steps(5);
        run = 1'b1;
        wait_lit(20, seen);
        check("restart_lit", seen, 1);
        check("restart_digit0", {sel_a, sel_b}, 2'b00);

        // reset mid-frame discards a pending value
        pulse_load(16'h1234);
        rst = 1'b1;
        step();
        rst = 1'b0;
        a0 = ack_cnt;
        steps(80);
        check("pending_dropped", ack_cnt - a0, 0);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            load = ($urandom_range(0, 19) == 0);
            if (load) value = rand_bcd();
            if ($urandom_range(0, 99) == 0) digit_en = 4'($urandom_range(0, 15));
            if (!run) run = ($urandom_range(0, 9) == 0);
            else if ($urandom_range(0, 399) == 0) run = 1'b0;
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;
        steps(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
